// File: rtl/adc_capture_sequencer.sv
// Scan sequencer for a muxed ADC: walks the enabled channels once per period
// tick, launches conversions, and streams {channel, sample} beats out over AXI-Stream.
module adc_capture_sequencer #(
  parameter int DATA_W  = 16,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [3:0]        cfg_ch_mask,
  input  logic [15:0]       cfg_period,
  input  logic [15:0]       cfg_num_scans,
  output logic [1:0]        adc_ch_sel,
  output logic              adc_convst,
  input  logic              adc_done,
  input  logic [DATA_W-1:0] adc_data,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W+1:0] m_tdata,
  output logic              m_tlast,
  output logic              busy,
  output logic              done,
  output logic              err_overrun,
  output logic              err_timeout,
  output logic [15:0]       scan_count
);

  localparam logic [15:0] SETTLE_M1  = 16'(SETTLE  > 0 ? SETTLE  - 1 : 0);
  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_SETTLE,
    S_CONVERT,
    S_OUTPUT
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [3:0]          r_mask;
  logic [15:0]         r_period;
  logic [15:0]         r_num_scans;
  logic [15:0]         r_timer;
  logic [15:0]         r_cnt;
  logic [1:0]          r_ch;
  logic                r_convst;
  logic [DATA_W+1:0]   r_tdata;
  logic                r_tlast;
  logic                r_done;
  logic                r_err_overrun;
  logic                r_err_timeout;
  logic [15:0]         r_scan_count;

  logic                w_tick;
  logic                w_has_next;
  logic [1:0]          w_next_ch;
  logic [15:0]         w_scan_inc;
  logic                w_start;
  logic                w_go_low;
  logic                w_go_next;
  logic                w_fire;
  logic                w_capture;
  logic                w_timeout;
  logic                w_scan_end;
  logic                w_final;

  function automatic logic [1:0] lowest_ch(input logic [3:0] mask);
    lowest_ch = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (mask[i]) lowest_ch = 2'(i);
  endfunction

  assign w_tick     = (r_state != S_IDLE) && (r_timer == r_period - 16'd1);
  assign w_scan_inc = r_scan_count + 16'd1;

  always_comb begin
    w_has_next = 1'b0;
    w_next_ch  = r_ch;
    for (int i = 3; i >= 0; i--)
      if (r_mask[i] && (2'(i) > r_ch)) begin
        w_has_next = 1'b1;
        w_next_ch  = 2'(i);
      end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_go_low     = 1'b0;
    w_go_next    = 1'b0;
    w_fire       = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    w_scan_end   = 1'b0;
    w_final      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cfg_start && (cfg_ch_mask != 4'd0)) begin
          w_state_next = S_SETTLE;
          w_start      = 1'b1;
        end
      end
      S_WAIT_TICK: begin
        if (w_tick) begin
          w_state_next = S_SETTLE;
          w_go_low     = 1'b1;
        end
      end
      S_SETTLE: begin
        if (r_cnt >= SETTLE_M1) begin
          w_state_next = S_CONVERT;
          w_fire       = 1'b1;
        end
      end
      S_CONVERT: begin
        if (adc_done) begin
          w_state_next = S_OUTPUT;
          w_capture    = 1'b1;
        end else if (r_cnt >= TIMEOUT_M1) begin
          w_state_next = S_IDLE;
          w_timeout    = 1'b1;
        end
      end
      S_OUTPUT: begin
        if (m_tready) begin
          if (w_has_next) begin
            w_state_next = S_SETTLE;
            w_go_next    = 1'b1;
          end else begin
            w_scan_end = 1'b1;
            if ((r_num_scans != 16'd0) && (w_scan_inc == r_num_scans)) begin
              w_state_next = S_IDLE;
              w_final      = 1'b1;
            end else begin
              w_state_next = S_WAIT_TICK;
            end
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    // Abort overrides every transition, including a same-cycle start.
    if (cfg_abort) begin
      w_state_next = S_IDLE;
      w_start      = 1'b0;
      w_go_low     = 1'b0;
      w_go_next    = 1'b0;
      w_fire       = 1'b0;
      w_capture    = 1'b0;
      w_timeout    = 1'b0;
      w_scan_end   = 1'b0;
      w_final      = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_mask        <= 4'd0;
      r_period      <= 16'd1;
      r_num_scans   <= 16'd0;
      r_timer       <= 16'd0;
      r_cnt         <= 16'd0;
      r_ch          <= 2'd0;
      r_convst      <= 1'b0;
      r_tdata       <= '0;
      r_tlast       <= 1'b0;
      r_done        <= 1'b0;
      r_err_overrun <= 1'b0;
      r_err_timeout <= 1'b0;
      r_scan_count  <= 16'd0;
    end else begin
      r_convst <= w_fire;
      r_done   <= w_final;

      if (w_start) begin
        r_mask        <= cfg_ch_mask;
        r_period      <= (cfg_period == 16'd0) ? 16'd1 : cfg_period;
        r_num_scans   <= cfg_num_scans;
        r_timer       <= 16'd0;
        r_ch          <= lowest_ch(cfg_ch_mask);
        r_err_overrun <= 1'b0;
        r_err_timeout <= 1'b0;
        r_scan_count  <= 16'd0;
      end else begin
        if (r_state != S_IDLE)
          r_timer <= w_tick ? 16'd0 : r_timer + 16'd1;
        // A tick only counts as a scan start in WAIT_TICK; elsewhere it is lost.
        if (w_tick && (r_state != S_WAIT_TICK) && !cfg_abort)
          r_err_overrun <= 1'b1;
        if (w_timeout)
          r_err_timeout <= 1'b1;
        if (w_go_low)
          r_ch <= lowest_ch(r_mask);
        else if (w_go_next)
          r_ch <= w_next_ch;
        if (w_scan_end)
          r_scan_count <= w_scan_inc;
      end

      if (w_start || w_go_low || w_go_next || w_fire)
        r_cnt <= 16'd0;
      else if ((r_state == S_SETTLE) || (r_state == S_CONVERT))
        r_cnt <= r_cnt + 16'd1;

      if (w_capture) begin
        r_tdata <= {r_ch, adc_data};
        r_tlast <= !w_has_next;
      end
    end
  end

  assign adc_ch_sel  = r_ch;
  assign adc_convst  = r_convst;
  assign m_tvalid    = (r_state == S_OUTPUT);
  assign m_tdata     = r_tdata;
  assign m_tlast     = r_tlast;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign err_overrun = r_err_overrun;
  assign err_timeout = r_err_timeout;
  assign scan_count  = r_scan_count;

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Randomized bench for adc_capture_sequencer: an ADC responder plus a
// timeline-level reference model predicting every beat, pulse and flag.
module tb_adc_capture_sequencer;

  localparam int DATA_W  = 16;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 255;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic              cfg_start;
  logic              cfg_abort;
  logic [3:0]        cfg_ch_mask;
  logic [15:0]       cfg_period;
  logic [15:0]       cfg_num_scans;
  logic [1:0]        adc_ch_sel;
  logic              adc_convst;
  logic              adc_done;
  logic [DATA_W-1:0] adc_data;
  logic              m_tvalid;
  logic              m_tready;
  logic [DATA_W+1:0] m_tdata;
  logic              m_tlast;
  logic              busy;
  logic              done;
  logic              err_overrun;
  logic              err_timeout;
  logic [15:0]       scan_count;

  adc_capture_sequencer #(.DATA_W(DATA_W), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_ch_mask(cfg_ch_mask), .cfg_period(cfg_period), .cfg_num_scans(cfg_num_scans),
    .adc_ch_sel(adc_ch_sel), .adc_convst(adc_convst), .adc_done(adc_done), .adc_data(adc_data),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .busy(busy), .done(done), .err_overrun(err_overrun), .err_timeout(err_timeout),
    .scan_count(scan_count)
  );

  always #5 ACLK = ~ACLK;

  int checkCount = 0;
  int failCount  = 0;
  int cyc        = 0;

  // Knobs set by the stimulus process
  bit adcAnswer = 1'b1;
  int adcLat    = 10;
  int readyMode = 0;
  int holdCnt   = 0;

  // Reference model state
  bit          expBusy    = 1'b0;
  bit          expTvalid  = 1'b0;
  bit          expTimeout = 1'b0;
  bit          expOverrun = 1'b0;
  logic [17:0] expTdata   = '0;
  bit          expTlast   = 1'b0;
  int          expConvAt  = -1;
  int          doneAt     = -1;
  int          ansAt      = -1;
  int          toAt       = -1;
  int          endCheckAt = -1;
  int          resetChkAt = -1;
  int          clearChkAt = -1;
  int          expScans   = 0;
  int          mPeriod    = 1;
  int          mNum       = 0;
  int          scanStart  = 0;
  int          idx        = 0;
  int          nCh        = 0;
  logic [1:0]  chList [4];
  int          doneSeen   = 0;
  int          convSeen   = 0;
  bit          ansNow;
  bit          hs;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic dropToIdle();
    expBusy   = 1'b0;
    expTvalid = 1'b0;
    expConvAt = -1;
    doneAt    = -1;
    ansAt     = -1;
    toAt      = -1;
  endtask

  // Drive ADC/ready inputs for this cycle, compare outputs, then advance the model.
  always @(negedge ACLK) begin
    cyc++;
    ansNow   = 1'b0;
    adc_done = 1'b0;
    if (ansAt == cyc) begin
      adc_done = 1'b1;
      adc_data = DATA_W'($urandom);
      ansNow   = 1'b1;
      ansAt    = -1;
    end else if (expTvalid && ($urandom_range(0, 3) == 0)) begin
      adc_done = 1'b1;
      adc_data = DATA_W'($urandom);
    end
    case (readyMode)
      1:       m_tready = 1'($urandom_range(0, 1));
      2: begin
        if (expTvalid && holdCnt < 50) begin
          m_tready = 1'b0;
          holdCnt++;
        end else m_tready = 1'b1;
      end
      default: m_tready = 1'b1;
    endcase

    if (resetChkAt == cyc) begin
      checkOutput("rst_convst", adc_convst, 0);
      checkOutput("rst_ch_sel", adc_ch_sel, 0);
      checkOutput("rst_tvalid", m_tvalid, 0);
      checkOutput("rst_tdata", m_tdata, 0);
      checkOutput("rst_tlast", m_tlast, 0);
      checkOutput("rst_err_overrun", err_overrun, 0);
      checkOutput("rst_scan_count", scan_count, 0);
    end
    if (clearChkAt == cyc) begin
      checkOutput("start_clr_overrun", err_overrun, 0);
      checkOutput("start_clr_scan_count", scan_count, 0);
    end
    checkOutput("busy", busy, expBusy);
    checkOutput("convst", adc_convst, cyc == expConvAt);
    checkOutput("tvalid", m_tvalid, expTvalid);
    checkOutput("done", done, cyc == doneAt);
    checkOutput("err_timeout", err_timeout, expTimeout);
    if (expTvalid) begin
      checkOutput("tdata", m_tdata, expTdata);
      checkOutput("tlast", m_tlast, expTlast);
    end
    if (endCheckAt == cyc) begin
      checkOutput("scan_end_count", scan_count, expScans & 32'hFFFF);
      checkOutput("scan_end_overrun", err_overrun, expOverrun);
    end
    if (done) doneSeen++;
    if (adc_convst) convSeen++;

    hs = expTvalid && m_tready;
    if (ARESET) begin
      dropToIdle();
      expTimeout = 1'b0;
      expOverrun = 1'b0;
      expScans   = 0;
      resetChkAt = cyc + 1;
    end else if (cfg_abort) begin
      dropToIdle();
    end else if (!expBusy) begin
      if (cfg_start && cfg_ch_mask != 4'd0) begin
        nCh = 0;
        for (int i = 0; i < 4; i++)
          if (cfg_ch_mask[i]) begin
            chList[nCh] = 2'(i);
            nCh++;
          end
        mPeriod    = (cfg_period == 16'd0) ? 1 : int'(cfg_period);
        mNum       = int'(cfg_num_scans);
        expBusy    = 1'b1;
        expTimeout = 1'b0;
        expOverrun = 1'b0;
        expScans   = 0;
        idx        = 0;
        scanStart  = cyc + 1;
        expConvAt  = cyc + 1 + SETTLE;
        clearChkAt = cyc + 1;
      end
    end else begin
      if (hs) begin
        expTvalid = 1'b0;
        if (idx < nCh - 1) begin
          idx++;
          expConvAt = cyc + 1 + SETTLE;
        end else begin
          expScans++;
          if (scanStart + mPeriod - 1 <= cyc) expOverrun = 1'b1;
          endCheckAt = cyc + 1;
          idx = 0;
          if (mNum != 0 && expScans == mNum) begin
            doneAt  = cyc + 1;
            expBusy = 1'b0;
          end else begin
            while (scanStart < cyc + 2) scanStart += mPeriod;
            expConvAt = scanStart + SETTLE;
          end
        end
      end
      if (cyc == expConvAt) begin
        checkOutput("ch_sel_at_convst", adc_ch_sel, chList[idx]);
        if (adcAnswer) ansAt = cyc + adcLat;
        toAt = cyc + TIMEOUT - 1;
      end
      if (ansNow) begin
        expTvalid = 1'b1;
        expTdata  = {chList[idx], adc_data};
        expTlast  = (idx == nCh - 1);
        toAt      = -1;
      end else if (cyc == toAt) begin
        expBusy    = 1'b0;
        expTimeout = 1'b1;
        toAt       = -1;
      end
    end
  end

  task automatic pulseAbort(input bit withStart);
    @(posedge ACLK); #1;
    cfg_abort = 1'b1;
    cfg_start = withStart;
    @(posedge ACLK); #1;
    cfg_abort = 1'b0;
    cfg_start = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    int k;
    k = 0;
    while (expBusy && k < limit) begin
      @(posedge ACLK);
      k++;
    end
    if (expBusy) begin
      checkOutput("idle_wait_expired", 1, 0);
      pulseAbort(1'b0);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input int period, input int num,
                               input int lat, input bit answer, input int rmode);
    @(posedge ACLK); #1;
    adcAnswer     = answer;
    adcLat        = lat;
    readyMode     = rmode;
    holdCnt       = 0;
    cfg_ch_mask   = mask;
    cfg_period    = 16'(period);
    cfg_num_scans = 16'(num);
    cfg_start     = 1'b1;
    @(posedge ACLK); #1;
    cfg_start     = 1'b0;
    cfg_ch_mask   = 4'($urandom);
    cfg_period    = 16'($urandom);
    cfg_num_scans = 16'($urandom);
    if (num != 0) begin
      waitIdle(20000);
      repeat (3) @(posedge ACLK);
      checkOutput("final_overrun", err_overrun, expOverrun);
      checkOutput("final_scan_count", scan_count, expScans & 32'hFFFF);
    end
  endtask

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int d0;
    int c0;
    int k;
    ARESET = 1'b1; cfg_start = 1'b0; cfg_abort = 1'b0;
    cfg_ch_mask = 4'd0; cfg_period = 16'd0; cfg_num_scans = 16'd0;
    adc_done = 1'b0; adc_data = '0; m_tready = 1'b1;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;
    repeat (2) @(posedge ACLK);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_err_timeout", err_timeout, 0);

    $display("[TB] start with empty mask");
    applyStimulus(4'b0000, 10, 1, 5, 1'b1, 0);
    repeat (5) @(posedge ACLK);

    $display("[TB] two-channel three-scan run");
    d0 = doneSeen;
    applyStimulus(4'b1010, 100, 3, 10, 1'b1, 0);
    checkOutput("run1_done_pulses", doneSeen - d0, 1);
    checkOutput("run1_scan_count", scan_count, 3);
    checkOutput("run1_busy", busy, 0);

    $display("[TB] period shorter than a scan");
    applyStimulus(4'b0001, 5, 4, 20, 1'b1, 0);
    checkOutput("run2_overrun", err_overrun, 1);

    $display("[TB] ADC never answers");
    c0 = convSeen;
    applyStimulus(4'b0100, 300, 1, 0, 1'b0, 0);
    checkOutput("run3_timeout", err_timeout, 1);
    checkOutput("run3_convsts", convSeen - c0, 1);

    $display("[TB] backpressure on first beat");
    applyStimulus(4'b0011, 200, 1, 3, 1'b1, 2);

    $display("[TB] continuous run with abort");
    d0 = doneSeen;
    applyStimulus(4'b0110, 60, 0, 5, 1'b1, 0);
    k = 0;
    while (expScans < 3 && k < 5000) begin @(posedge ACLK); k++; end
    @(posedge ACLK); #1;
    cfg_ch_mask = 4'b1111; cfg_start = 1'b1;
    @(posedge ACLK); #1;
    cfg_start = 1'b0;
    k = 0;
    while (expScans < 7 && k < 5000) begin @(posedge ACLK); k++; end
    checkOutput("run5_reached_7", expScans >= 7, 1);
    pulseAbort(1'b1);
    repeat (3) @(posedge ACLK);
    checkOutput("run5_busy_after_abort", busy, 0);
    checkOutput("run5_scan_count", scan_count, 7);
    checkOutput("run5_no_done", doneSeen - d0, 0);
    repeat (40) @(posedge ACLK);

    $display("[TB] reset during conversion");
    c0 = convSeen;
    @(posedge ACLK); #1;
    adcAnswer = 1'b1; adcLat = 30; readyMode = 0;
    cfg_ch_mask = 4'b1111; cfg_period = 16'd100; cfg_num_scans = 16'd2; cfg_start = 1'b1;
    @(posedge ACLK); #1;
    cfg_start = 1'b0;
    k = 0;
    while (convSeen == c0 && k < 200) begin @(posedge ACLK); k++; end
    repeat (5) @(posedge ACLK);
    #1 ARESET = 1'b1;
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    repeat (40) @(posedge ACLK);
    applyStimulus(4'b1001, 80, 2, 7, 1'b1, 0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 8; r++) begin
      applyStimulus(4'($urandom_range(1, 15)), $urandom_range(0, 80), $urandom_range(1, 3),
                    $urandom_range(1, 25), 1'b1, $urandom_range(0, 1));
      repeat (5) @(posedge ACLK);
    end

    repeat (5) @(posedge ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
